rr_arbiter: RTL and testbench

Parametrised, registered round-robin arbiter: the successor to the fixed-priority `day14` arbiter, with the same `req_i`/`gnt_o` port style. It adds three things: rotating priority for fairness, grant hold for multi-cycle ownership, and an optional hold-limit preemption. It sits between NUM_PORTS requesters and one shared resource, and drives a one-hot grant plus an encoded grant index.

---
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with rotating priority and grant hold.
// Optional hold-limit preemption is compiled in with RR_ARB_HOLD_LIMIT_EN.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         req_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic                         gnt_valid_o
);

  localparam int IDW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_PORTS < 2 || NUM_PORTS > 32) begin : g_bad_num_ports
    $error("rr_arbiter: NUM_PORTS out of range 2..32");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD out of range 1..255");
  end

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic                 gnt_valid_q, gnt_valid_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [7:0]           hold_cnt_q, hold_cnt_d;
`endif

  logic [NUM_PORTS-1:0] cand_s;
  logic                 owner_req_s;
  logic                 preempt_s;
  logic                 keep_s;
  logic                 found_s;
  logic [IDW-1:0]       win_s;

  // Candidates exclude the current owner; gnt_q is one-hot so it doubles as the owner mask.
  always_comb begin
    cand_s      = req_i & ~gnt_q;
    owner_req_s = |(req_i & gnt_q);
`ifdef RR_ARB_HOLD_LIMIT_EN
    preempt_s   = (state_q == BUSY) && (hold_cnt_q == 8'(MAX_HOLD)) &&
                  owner_req_s && (|cand_s);
`else
    preempt_s   = 1'b0;
`endif
    keep_s      = (state_q == BUSY) && owner_req_s && !preempt_s;
  end

  // Rotating search: first candidate at or after ptr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found_s && cand_s[(int'(ptr_q) + i) % NUM_PORTS]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(ptr_q) + i) % NUM_PORTS);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state: hold the owner, hand over directly, or fall back to idle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    if (keep_s) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
      // Uncontended owner at the limit keeps the grant and restarts its window.
      hold_cnt_d = (hold_cnt_q == 8'(MAX_HOLD)) ? 8'd1 : hold_cnt_q + 8'd1;
`endif
    end else if (found_s) begin
      state_d     = BUSY;
      gnt_d       = NUM_PORTS'(1) << win_s;
      gnt_id_d    = win_s;
      gnt_valid_d = 1'b1;
      ptr_d       = (int'(win_s) == NUM_PORTS - 1) ? '0 : win_s + IDW'(1);
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_d  = 8'd1;
`endif
    end else begin
      state_d     = IDLE;
      gnt_d       = '0;
      gnt_id_d    = '0;
      gnt_valid_d = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_d  = 8'd0;
`endif
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUM_PORTS=4, MAX_HOLD=3).
module tb_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_valid_o;

  int total;
  int bad;

  rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .gnt_id_o   (gnt_id_o),
    .gnt_valid_o(gnt_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive req, let one rising edge sample it, then settle 1 time unit past the edge.
  task automatic tick(input logic [3:0] r);
    req_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset_n = 1'b0;
    req_i   = r;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'b1111);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_id_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold: gnt=%b id=%0d valid=%b, expected 0000/0/0", gnt_o, gnt_id_o, gnt_valid_o);
    end
    reset_n = 1'b1;
    tick(4'b1111);
    total++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: gnt=%b id=%0d valid=%b, expected 0001/0/1", gnt_o, gnt_id_o, gnt_valid_o);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] reqs [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp_g[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_i[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset(4'b0000);
    tick(4'b1111);
    total++;
    if (gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL rot_start: gnt=%b expected 0001", gnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick(reqs[i]);
      total++;
      if (gnt_o !== exp_g[i] || gnt_id_o !== exp_i[i] || gnt_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL rot_step%0d: gnt=%b id=%0d valid=%b, expected %b/%0d/1",
                 i, gnt_o, gnt_id_o, gnt_valid_o, exp_g[i], exp_i[i]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset(4'b0000);
    tick(4'b0100);
    tick(4'b0000);
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_id_o !== 2'd0) begin
      bad++;
      $display("FAIL wrap_idle: gnt=%b id=%0d valid=%b, expected 0000/0/0", gnt_o, gnt_id_o, gnt_valid_o);
    end
    tick(4'b0101);
    total++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
      bad++;
      $display("FAIL wrap_port0: gnt=%b id=%0d, expected 0001/0", gnt_o, gnt_id_o);
    end
    tick(4'b0100);
    total++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2) begin
      bad++;
      $display("FAIL wrap_port2: gnt=%b id=%0d, expected 0100/2", gnt_o, gnt_id_o);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [3:0] exp;
`ifdef RR_ARB_HOLD_LIMIT_EN
    n = 3;
`else
    n = 10;
`endif
    do_reset(4'b0000);
    tick(4'b0010);
    total++;
    if (gnt_o !== 4'b0010) begin
      bad++;
      $display("FAIL hold_start: gnt=%b expected 0010", gnt_o);
    end
    for (int i = 0; i < n; i++) begin
      tick(4'b0110);
`ifdef RR_ARB_HOLD_LIMIT_EN
      exp = (i < 2) ? 4'b0010 : 4'b0100;
`else
      exp = 4'b0010;
`endif
      total++;
      if (gnt_o !== exp) begin
        bad++;
        $display("FAIL hold_cyc%0d: gnt=%b expected %b", i, gnt_o, exp);
      end
    end
    tick(4'b0100);
    total++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2) begin
      bad++;
      $display("FAIL hold_release: gnt=%b id=%0d, expected 0100/2", gnt_o, gnt_id_o);
    end
  endtask

  task automatic test_uncontended();
    do_reset(4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick(4'b1000);
      total++;
      if (gnt_o !== 4'b1000 || gnt_valid_o !== 1'b1 || gnt_id_o !== 2'd3) begin
        bad++;
        $display("FAIL uncont_cyc%0d: gnt=%b id=%0d valid=%b, expected 1000/3/1",
                 i, gnt_o, gnt_id_o, gnt_valid_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(4'b0000);
    tick(4'b0100);
    total++;
    if (gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_own: gnt=%b expected 0100", gnt_o);
    end
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_id_o !== 2'd0) begin
      bad++;
      $display("FAIL midrst_clear: gnt=%b id=%0d valid=%b, expected 0000/0/0", gnt_o, gnt_id_o, gnt_valid_o);
    end
    reset_n = 1'b1;
    tick(4'b0110);
    total++;
    if (gnt_o !== 4'b0010 || gnt_id_o !== 2'd1 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_regrant: gnt=%b id=%0d valid=%b, expected 0010/1/1", gnt_o, gnt_id_o, gnt_valid_o);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    req_i   = 4'b0000;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold();
    test_uncontended();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
